// File: rtl/cpu_defs.sv
// Shared CPU definitions: fetch-stage types, reset vector and branch classes.
package cpu_defs;

  localparam logic [31:0] RESET_PC_DEF = 32'hBFC0_0000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DROP
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
    logic        adel;
  } fetch_entry_t;

  // Branch-class encodings consumed by decode/execute.
  localparam logic [2:0] BR_NONE = 3'd0;
  localparam logic [2:0] BR_COND = 3'd1;
  localparam logic [2:0] BR_J    = 3'd2;
  localparam logic [2:0] BR_JAL  = 3'd3;
  localparam logic [2:0] BR_JR   = 3'd4;
  localparam logic [2:0] BR_JALR = 3'd5;

  function automatic logic word_aligned(input logic [31:0] a);
    return a[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/if_fifo.sv
// Synchronous FIFO of fetch entries with clear and a registered head entry.
module if_fifo
  import cpu_defs::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  fetch_entry_t push_data_i,
  input  logic         pop_i,
  input  logic         clear_i,
  output logic [CW-1:0] count_o,
  output fetch_entry_t head_o
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  head_q, head_d;
  logic [AW-1:0] rd_q, wr_q, rd_nxt;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  assign do_pop  = pop_i && (cnt_q != '0);
  assign do_push = push_i && ((cnt_q != CW'(DEPTH)) || do_pop);
  assign rd_nxt  = rd_q + AW'(1);

  // Head is precomputed so the output is a flop rather than a read mux.
  always_comb begin
    head_d = head_q;
    if (do_pop) begin
      if (cnt_q > CW'(1))  head_d = mem_q[rd_nxt];
      else if (do_push)    head_d = push_data_i;
      else                 head_d = '0;
    end else if (do_push && cnt_q == '0) begin
      head_d = push_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      head_q <= '0;
    end else if (clear_i) begin
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      head_q <= '0;
    end else begin
      if (do_pop)  rd_q <= rd_nxt;
      if (do_push) wr_q <= wr_q + AW'(1);
      cnt_q  <= cnt_q + CW'(do_push) - CW'(do_pop);
      head_q <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear_i) mem_q[wr_q] <= push_data_i;
  end

  assign count_o = cnt_q;
  assign head_o  = head_q;

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: PC generation, single-outstanding memory reads,
// redirect handling with wrong-path drop, and a buffered decode handoff.
module if_fetch
  import cpu_defs::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_word,
  output logic [31:0] inst_pc,
  output logic        inst_adel
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e  state_q;
  logic [31:0]   pc_q, pc_d, addr_q;
  logic          req_q, drop_pend_q;
  logic          push, adv, outstanding, free_slot;
  fetch_entry_t  push_entry, head;
  logic [CW-1:0] fifo_cnt;

  assign outstanding = (state_q == S_WAIT) || (state_q == S_DROP);
  assign free_slot   = (int'(fifo_cnt) + (outstanding ? 1 : 0)) < FIFO_DEPTH;

  always_comb begin
    push       = 1'b0;
    adv        = 1'b0;
    push_entry = '0;
    case (state_q)
      S_IDLE: if (!redirect_valid && free_slot && !word_aligned(pc_q)) begin
        push       = 1'b1;
        adv        = 1'b1;
        push_entry = '{word: 32'h0, pc: pc_q, adel: 1'b1};
      end
      S_WAIT: if (inst_data_ok && !redirect_valid) begin
        push       = 1'b1;
        adv        = 1'b1;
        push_entry = '{word: inst_rdata, pc: pc_q, adel: 1'b0};
      end
      default: ;
    endcase
  end

  assign pc_d = redirect_valid ? redirect_pc : (adv ? pc_q + 32'd4 : pc_q);

  // A redirect during S_REQ cannot retract the request; remember it so the
  // accepted read is routed to S_DROP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      req_q       <= 1'b0;
      addr_q      <= RESET_PC;
      drop_pend_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      case (state_q)
        S_IDLE: if (!redirect_valid && free_slot && word_aligned(pc_q)) begin
          state_q     <= S_REQ;
          req_q       <= 1'b1;
          addr_q      <= pc_q;
          drop_pend_q <= 1'b0;
        end
        S_REQ: begin
          if (inst_addr_ok) begin
            req_q       <= 1'b0;
            drop_pend_q <= 1'b0;
            state_q     <= (redirect_valid || drop_pend_q) ? S_DROP : S_WAIT;
          end else if (redirect_valid) begin
            drop_pend_q <= 1'b1;
          end
        end
        S_WAIT: begin
          if (inst_data_ok)        state_q <= S_IDLE;
          else if (redirect_valid) state_q <= S_DROP;
        end
        S_DROP: if (inst_data_ok) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  if_fifo #(.DEPTH(FIFO_DEPTH), .CW(CW)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (push),
    .push_data_i(push_entry),
    .pop_i      (inst_valid && inst_ready),
    .clear_i    (redirect_valid),
    .count_o    (fifo_cnt),
    .head_o     (head)
  );

  assign inst_req   = req_q;
  assign inst_addr  = addr_q;
  assign inst_valid = (fifo_cnt != '0);
  assign inst_word  = head.word;
  assign inst_pc    = head.pc;
  assign inst_adel  = head.adel;

endmodule

// File: tb/tb_if_fetch.sv
// Randomized bench for if_fetch: memory responder plus an in-order fetch-stream
// reference (expected PC sequence restarted at each redirect).
module tb_if_fetch;
  import cpu_defs::*;

  localparam logic [31:0] RPC = 32'hBFC0_0000;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        inst_req, inst_addr_ok = 1'b0, inst_data_ok = 1'b0;
  logic [31:0] inst_addr, inst_rdata = '0;
  logic        redirect_valid = 1'b0, inst_ready = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_valid, inst_adel;
  logic [31:0] inst_word, inst_pc;

  always #5 clk = ~clk;

  if_fetch #(.RESET_PC(RPC), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_word(inst_word), .inst_pc(inst_pc), .inst_adel(inst_adel)
  );

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  // knobs
  int ready_mode = 0;  // 0 always, 1 never, 2 random
  int aok_mode   = 0;  // 0 immediate, 1 random delay, 2 never
  int lat_min = 1, lat_max = 1, redir_prob = 0;
  int trig_mode = 0;   // 1 redirect in WAIT, 2 redirect with data_ok, 3 immediate
  logic [31:0] trig_addr, trig_target;

  // memory and scoreboard state
  logic        pend = 0, held = 0, arm_next = 0;
  int          pend_cnt = 0, aok_wait = 0;
  logic [31:0] pend_addr, dok_addr, held_addr, exp_pc = RPC;
  int          cyc = 0, dok_cnt = 0, pops = 0, redir_cnt = 0;
  logic [31:0] acc_q[$], pop_pc_q[$], pop_word_q[$];
  logic        pop_adel_q[$];

  task automatic cycle();
    logic [31:0] t;
    @(negedge clk);
    cyc++;
    redirect_valid = 1'b0;
    if (!rst_n) begin
      pend = 0; inst_addr_ok = 0; inst_data_ok = 0; held = 0;
      return;
    end
    if (pend && pend_cnt == 0) begin
      inst_data_ok = 1'b1; inst_rdata = memfn(pend_addr);
      dok_addr = pend_addr; pend = 0; dok_cnt++;
    end else begin
      inst_data_ok = 1'b0; inst_rdata = $urandom;
      if (pend) pend_cnt--;
    end
    inst_addr_ok = 1'b0;
    if (inst_req) begin
      chk("req_aligned", {30'd0, inst_addr[1:0]}, 32'd0);
      chk("one_outstanding", {31'd0, pend}, 32'd0);
      if (held) chk("req_addr_stable", inst_addr, held_addr);
      if (!pend && aok_mode != 2 && aok_wait == 0) begin
        inst_addr_ok = 1'b1; pend = 1; pend_addr = inst_addr;
        acc_q.push_back(inst_addr);
        pend_cnt = $urandom_range(lat_max, lat_min) - 1;
        aok_wait = (aok_mode == 1) ? $urandom_range(2) : 0;
        if (trig_mode == 1 && inst_addr == trig_addr) begin
          pend_cnt = 2; arm_next = 1; trig_mode = 0;
        end
      end else if (aok_wait > 0) aok_wait--;
    end
    held = inst_req && !inst_addr_ok;
    held_addr = inst_addr;
    if (arm_next && !inst_addr_ok) begin
      redirect_valid = 1'b1; redirect_pc = trig_target; arm_next = 0;
    end
    if (trig_mode == 2 && inst_data_ok && dok_addr == trig_addr) begin
      redirect_valid = 1'b1; redirect_pc = trig_target; trig_mode = 0;
    end else if (trig_mode == 3) begin
      redirect_valid = 1'b1; redirect_pc = trig_target; trig_mode = 0;
    end else if (redir_prob > 0 && $urandom_range(99) < redir_prob) begin
      t = $urandom;
      t[1:0] = ($urandom_range(7) == 0) ? 2'b10 : 2'b00;
      redirect_valid = 1'b1; redirect_pc = t;
    end
    case (ready_mode)
      0: inst_ready = 1'b1;
      1: inst_ready = 1'b0;
      default: inst_ready = $urandom_range(1);
    endcase
    if (redirect_valid) begin
      exp_pc = redirect_pc; redir_cnt++;
      pop_pc_q.delete(); pop_word_q.delete(); pop_adel_q.delete(); acc_q.delete();
    end else if (inst_valid && inst_ready) begin
      chk("pop_pc", inst_pc, exp_pc);
      chk("pop_adel", {31'd0, inst_adel}, {31'd0, exp_pc[1:0] != 2'b00});
      chk("pop_word", inst_word, (exp_pc[1:0] != 2'b00) ? 32'd0 : memfn(exp_pc));
      pop_pc_q.push_back(inst_pc); pop_word_q.push_back(inst_word);
      pop_adel_q.push_back(inst_adel);
      exp_pc = exp_pc + 32'd4; pops++;
    end
  endtask

  task automatic clear_tb();
    pend = 0; held = 0; arm_next = 0; aok_wait = 0; trig_mode = 0;
    inst_addr_ok = 0; inst_data_ok = 0; redirect_valid = 0; inst_ready = 0;
    exp_pc = RPC; dok_cnt = 0; pops = 0; redir_cnt = 0;
    acc_q.delete(); pop_pc_q.delete(); pop_word_q.delete(); pop_adel_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_tb();
    @(negedge clk);
    chk("rst_req", {31'd0, inst_req}, 32'd0);
    chk("rst_addr", inst_addr, RPC);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_word", inst_word, 32'd0);
    chk("rst_pc", inst_pc, 32'd0);
    chk("rst_adel", {31'd0, inst_adel}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_valid;
    // 1: basic streaming and first-valid latency
    ready_mode = 0; aok_mode = 0; lat_min = 1; lat_max = 1;
    do_reset();
    first_valid = -1;
    for (int i = 0; i < 30; i++) begin
      cycle();
      if (first_valid < 0 && inst_valid) first_valid = cyc;
    end
    chk("first_valid_latency", 32'(first_valid), 32'd3);
    chk("acc_count_ge3", {31'd0, acc_q.size() >= 3}, 32'd1);
    if (acc_q.size() >= 3)
      for (int i = 0; i < 3; i++) chk("acc_seq", acc_q[i], RPC + 32'(4 * i));

    // 2: stall fills exactly two entries and stops requesting
    do_reset();
    ready_mode = 1;
    repeat (10) cycle();
    chk("stall_resp_count", 32'(dok_cnt), 32'd2);
    chk("stall_req_low", {31'd0, inst_req}, 32'd0);
    chk("stall_valid", {31'd0, inst_valid}, 32'd1);
    ready_mode = 0;
    repeat (12) cycle();
    chk("stall_pops_ge2", {31'd0, pop_pc_q.size() >= 2}, 32'd1);
    if (pop_pc_q.size() >= 2) begin
      chk("stall_pop0", pop_pc_q[0], RPC);
      chk("stall_pop1", pop_pc_q[1], RPC + 32'd4);
    end

    // 3: redirect while waiting for BFC00008
    do_reset();
    ready_mode = 0; trig_mode = 1; trig_addr = RPC + 32'd8; trig_target = 32'h8000_1000;
    repeat (20) cycle();
    chk("t3_redirects", 32'(redir_cnt), 32'd1);
    chk("t3_first_pc", (pop_pc_q.size() > 0) ? pop_pc_q[0] : 32'hFFFF_FFFF, 32'h8000_1000);

    // 4: redirect in the data_ok cycle of BFC00004
    do_reset();
    ready_mode = 0; trig_mode = 2; trig_addr = RPC + 32'd4; trig_target = 32'h8000_2000;
    repeat (20) cycle();
    chk("t4_redirects", 32'(redir_cnt), 32'd1);
    chk("t4_first_pc", (pop_pc_q.size() > 0) ? pop_pc_q[0] : 32'hFFFF_FFFF, 32'h8000_2000);

    // 5: misaligned redirect produces adel entries without memory requests
    trig_mode = 3; trig_target = 32'h8000_0002;
    repeat (10) cycle();
    chk("t5_pops_ge2", {31'd0, pop_pc_q.size() >= 2}, 32'd1);
    if (pop_pc_q.size() >= 2) begin
      chk("t5_pc0", pop_pc_q[0], 32'h8000_0002);
      chk("t5_adel0", {31'd0, pop_adel_q[0]}, 32'd1);
      chk("t5_word0", pop_word_q[0], 32'd0);
      chk("t5_pc1", pop_pc_q[1], 32'h8000_0006);
      chk("t5_adel1", {31'd0, pop_adel_q[1]}, 32'd1);
    end
    chk("t5_no_requests", 32'(acc_q.size()), 32'd0);

    // 5b: PC wraps past the top of the address space
    trig_mode = 3; trig_target = 32'hFFFF_FFF8;
    repeat (24) cycle();
    chk("wrap_pc2", (pop_pc_q.size() > 2) ? pop_pc_q[2] : 32'hFFFF_FFFF, 32'h0000_0000);

    // 6: asynchronous reset while a request is held
    do_reset();
    aok_mode = 2;
    for (int i = 0; i < 20 && !inst_req; i++) cycle();
    chk("t6_reached_req", {31'd0, inst_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_req", {31'd0, inst_req}, 32'd0);
    chk("t6_async_addr", inst_addr, RPC);
    clear_tb();
    aok_mode = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) cycle();
    chk("t6_restart", (acc_q.size() > 0) ? acc_q[0] : 32'hFFFF_FFFF, RPC);

    // 7: randomized traffic with random stalls, latencies and redirects
    do_reset();
    ready_mode = 2; aok_mode = 1; lat_min = 1; lat_max = 3; redir_prob = 3;
    repeat (3000) cycle();
    redir_prob = 0;
    chk("rand_progress", {31'd0, pops > 200}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
